pool1_scheduler: RTL and testbench

- Sequencing controller for 2x2 max-pooling in the Pool1 stage.
- Reads row pairs of packed 16-bit activations from the input BRAM, two activations per 32-bit word.
- Drives the external pairwise max comparator three times per window, then writes one 16-bit max per window to the output BRAM.
- Sits between the conv output buffer and the pooled-feature BRAM. Started once per feature-map channel by the layer controller.

---
 rtl/pool_pkg.sv | 24 ++
 rtl/pool1_addr_gen.sv | 61 ++++++
 rtl/pool1_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_pool1_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the Pool1 2x2 max-pooling scheduler.
// Contents: FSM state encoding, data/word widths, output write-enable pattern.
package pool_pkg;

    localparam int DATA_W = 16;
    localparam int WORD_W = 32;

    localparam logic [1:0] OUT_WE_FULL = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        RD_TOP,
        RD_BOT,
        CAP_TOP,
        CMP_TOP,
        CMP_BOT,
        WAIT_P,
        CMP_FIN,
        WAIT_F,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/pool1_addr_gen.sv
// Window address generator for the Pool1 scheduler.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            reinitialise all counters for a new map
//   advance         step to the next 2x2 window (issued once per output write)
//   words, rows     latched map geometry (32-bit words per row, pixel rows)
//   row_addr        input word address of the current top row
//   col             current word column within the row pair
//   out_ptr         output address of the current window's result
//   last            current window is the final one of the map
module pool1_addr_gen #(
    parameter int unsigned AW       = 10,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [AW-1:0] words,
    input  logic [AW-1:0] rows,
    output logic [AW-1:0] row_addr,
    output logic [AW-1:0] col,
    output logic [AW-1:0] out_ptr,
    output logic          last
);

    logic [AW-1:0] row_idx;
    logic          col_last;

    assign col_last = (col == words - AW'(1));

    // Last window when the next row pair would not be complete; widened so
    // row_idx + 3 cannot wrap and drop an odd final row incorrectly.
    assign last = col_last &&
                  (({2'b00, row_idx} + (AW+2)'(3)) >= {2'b00, rows});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_addr <= '0;
            col      <= '0;
            out_ptr  <= '0;
            row_idx  <= '0;
        end else if (load) begin
            row_addr <= AW'(IN_BASE);
            col      <= '0;
            out_ptr  <= AW'(OUT_BASE);
            row_idx  <= '0;
        end else if (advance) begin
            out_ptr <= out_ptr + AW'(1);
            if (col_last) begin
                col      <= '0;
                row_addr <= row_addr + words + words;
                row_idx  <= row_idx + AW'(2);
            end else begin
                col <= col + AW'(1);
            end
        end
    end

endmodule

// File: rtl/pool1_scheduler.sv
// Pool1 2x2 max-pooling sequencer.
// Reads a top/bottom word pair (two 16-bit pixels each) per window, drives an
// external pairwise max comparator three times, writes one 16-bit result.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    start pulse (accepted only in IDLE)
//   cfg_words, cfg_rows      map width in words, map height in rows
//   busy, done, err          status: running, completion pulse, sticky error
//   in_en/in_addr/in_rdata   input BRAM read port (1-cycle read latency)
//   cmp_valid/cmp_a/cmp_b    comparator operand issue
//   cmp_res_valid/cmp_res    comparator result return (in order)
//   out_we/out_addr/out_wdata output BRAM write port
module pool1_scheduler
    import pool_pkg::*;
#(
    parameter int unsigned AW       = 10,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     cfg_words,
    input  logic [AW-1:0]     cfg_rows,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              in_en,
    output logic [AW-1:0]     in_addr,
    input  logic [WORD_W-1:0] in_rdata,
    output logic              cmp_valid,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_res_valid,
    input  logic [DATA_W-1:0] cmp_res,
    output logic [1:0]        out_we,
    output logic [AW-1:0]     out_addr,
    output logic [DATA_W-1:0] out_wdata
);

    state_t state, state_nx;

    logic [AW-1:0]     words_q, rows_q;
    logic [WORD_W-1:0] top_q, bot_q;
    logic [DATA_W-1:0] p0_q, p1_q, wdata_q;
    logic [1:0]        res_cnt;
    logic              err_q;

    logic [AW-1:0] row_addr, col, out_ptr;
    logic          last;

    logic start_ok, cfg_empty, res_in_pair, pair_done, spurious;

    assign start_ok    = start && (state == IDLE);
    assign cfg_empty   = (cfg_words == '0) || (cfg_rows < AW'(2));
    assign res_in_pair = cmp_res_valid && ((state == CMP_BOT) || (state == WAIT_P));
    // Second pair result arriving this cycle completes the pair.
    assign pair_done   = res_in_pair && (state == WAIT_P) && (res_cnt == 2'd1);
    assign spurious    = cmp_res_valid &&
                         (state inside {IDLE, RD_TOP, RD_BOT, CAP_TOP, CMP_TOP, CMP_FIN, WRITE});

    pool1_addr_gen #(
        .AW       (AW),
        .IN_BASE  (IN_BASE),
        .OUT_BASE (OUT_BASE)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .advance  (state == WRITE),
        .words    (words_q),
        .rows     (rows_q),
        .row_addr (row_addr),
        .col      (col),
        .out_ptr  (out_ptr),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = cfg_empty ? DONE : RD_TOP;
            RD_TOP:  state_nx = RD_BOT;
            RD_BOT:  state_nx = CAP_TOP;
            CAP_TOP: state_nx = CMP_TOP;
            CMP_TOP: state_nx = CMP_BOT;
            CMP_BOT: state_nx = WAIT_P;
            WAIT_P:  if (pair_done) state_nx = CMP_FIN;
            CMP_FIN: state_nx = WAIT_F;
            WAIT_F:  if (cmp_res_valid) state_nx = WRITE;
            WRITE:   state_nx = last ? DONE : RD_TOP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        err       = err_q;
        in_en     = 1'b0;
        in_addr   = '0;
        cmp_valid = 1'b0;
        cmp_a     = '0;
        cmp_b     = '0;
        out_we    = '0;
        out_addr  = '0;
        out_wdata = wdata_q;
        case (state)
            RD_TOP: begin
                in_en   = 1'b1;
                in_addr = row_addr + col;
            end
            RD_BOT: begin
                in_en   = 1'b1;
                in_addr = row_addr + words_q + col;
            end
            CMP_TOP: begin
                cmp_valid = 1'b1;
                cmp_a     = top_q[DATA_W-1:0];
                cmp_b     = top_q[WORD_W-1:DATA_W];
            end
            CMP_BOT: begin
                cmp_valid = 1'b1;
                cmp_a     = bot_q[DATA_W-1:0];
                cmp_b     = bot_q[WORD_W-1:DATA_W];
            end
            CMP_FIN: begin
                cmp_valid = 1'b1;
                cmp_a     = p0_q;
                cmp_b     = p1_q;
            end
            WRITE: begin
                out_we   = OUT_WE_FULL;
                out_addr = out_ptr;
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after in_en, so each word is registered on
    // the edge leaving the state after its read: top leaving RD_BOT, bottom
    // leaving CAP_TOP. Both are then stable for their comparator issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            rows_q  <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            wdata_q <= '0;
            res_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                words_q <= cfg_words;
                rows_q  <= cfg_rows;
            end
            if (spurious)      err_q <= 1'b1;
            else if (start_ok) err_q <= 1'b0;

            if (state == RD_BOT)  top_q <= in_rdata;
            if (state == CAP_TOP) bot_q <= in_rdata;

            if (state == RD_TOP) begin
                res_cnt <= '0;
            end else if (res_in_pair) begin
                if (res_cnt == 2'd0) p0_q <= cmp_res;
                else                 p1_q <= cmp_res;
                res_cnt <= res_cnt + 2'd1;
            end

            if ((state == WAIT_F) && cmp_res_valid) wdata_q <= cmp_res;
        end
    end

endmodule

// File: tb/tb_pool1_scheduler.sv
// Self-checking bench for pool1_scheduler: BRAM and comparator responders,
// directed scenarios plus randomized maps checked against a reference model.
module tb_pool1_scheduler;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_words, cfg_rows;
    logic          busy, done, err;
    logic          in_en;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_rdata;
    logic          cmp_valid;
    logic [15:0]   cmp_a, cmp_b;
    logic          cmp_res_valid;
    logic [15:0]   cmp_res;
    logic [1:0]    out_we;
    logic [AW-1:0] out_addr;
    logic [15:0]   out_wdata;

    always #5 clk = ~clk;

    pool1_scheduler #(
        .AW       (AW),
        .IN_BASE  (0),
        .OUT_BASE (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_words     (cfg_words),
        .cfg_rows      (cfg_rows),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .in_en         (in_en),
        .in_addr       (in_addr),
        .in_rdata      (in_rdata),
        .cmp_valid     (cmp_valid),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .cmp_res_valid (cmp_res_valid),
        .cmp_res       (cmp_res),
        .out_we        (out_we),
        .out_addr      (out_addr),
        .out_wdata     (out_wdata)
    );

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Input BRAM and fixed-latency in-order comparator.
    logic [31:0] mem [0:1023];
    int          lat = 1;
    logic        pv [0:7];
    logic [15:0] pd [0:7];
    logic        inj_v = 1'b0;
    logic [15:0] inj_d = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_rdata <= '0;
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            if (in_en) in_rdata <= mem[in_addr];
            pv[0] <= cmp_valid;
            pd[0] <= smax(cmp_a, cmp_b);
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign cmp_res_valid = pv[lat-1] | inj_v;
    assign cmp_res       = inj_v ? inj_d : pd[lat-1];

    // Activity monitor, sampled mid-cycle.
    int          en_cnt, cv_cnt, done_cnt, res_seen, wr_cnt, early_wr, bad_we;
    logic [15:0] wr_addr [$];
    logic [15:0] wr_data [$];

    always @(negedge clk) begin
        if (in_en)         en_cnt++;
        if (cmp_valid)     cv_cnt++;
        if (done)          done_cnt++;
        if (cmp_res_valid) res_seen++;
        if (out_we != 2'b00) begin
            wr_cnt++;
            if (out_we != 2'b11)       bad_we++;
            if (res_seen < 3 * wr_cnt) early_wr++;
            wr_addr.push_back(16'(out_addr));
            wr_data.push_back(out_wdata);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0; cv_cnt = 0; done_cnt = 0; res_seen = 0;
        wr_cnt = 0; early_wr = 0; bad_we = 0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    function automatic logic [31:0] pix_word(input int r, input int w);
        logic [15:0] lo, hi;
        lo = 16'(r * 16 + 2 * w);
        hi = 16'(r * 16 + 2 * w + 1);
        return {hi, lo};
    endfunction

    // Reference: every complete row pair, every word column, max of 4 pixels.
    task automatic run_map(input int w, input int r, input int l, input bit extra, input string tag);
        logic [15:0] ea [$];
        logic [15:0] ed [$];
        logic [31:0] t, b;
        int          n, base;
        lat = l;
        if (w != 0 && r >= 2) begin
            for (int pr = 0; pr < r / 2; pr++) begin
                for (int c = 0; c < w; c++) begin
                    base = (2 * pr * w + c) % 1024;
                    t = mem[base];
                    b = mem[(base + w) % 1024];
                    ea.push_back(16'((pr * w + c) % 1024));
                    ed.push_back(smax(smax(t[15:0], t[31:16]), smax(b[15:0], b[31:16])));
                end
            end
        end
        clear_mon();
        @(negedge clk);
        cfg_words = AW'(w);
        cfg_rows  = AW'(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_words = AW'($urandom);
        cfg_rows  = AW'($urandom);
        if (extra) begin
            repeat (3) @(negedge clk);
            if (busy) begin
                cfg_words = 7; cfg_rows = 9; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_nwrites"}, wr_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], ed[i]);
        end
        chk({tag, "_we_pat"}, bad_we, 0);
        chk({tag, "_early_wr"}, early_wr, 0);
        if (ea.size() == 0) begin
            chk({tag, "_no_rd"}, en_cnt, 0);
            chk({tag, "_no_cmp"}, cv_cnt, 0);
        end else begin
            chk({tag, "_rd_cnt"}, en_cnt, 2 * ea.size());
            chk({tag, "_cmp_cnt"}, cv_cnt, 3 * ea.size());
        end
    endtask

    task automatic load_ramp(input int w, input int r);
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int rr = 0; rr < r; rr++)
            for (int ww = 0; ww < w; ww++)
                mem[rr * w + ww] = pix_word(rr, ww);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cfg_words = '0; cfg_rows = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_mon();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_en", in_en, 0);
        chk("rst_cmp_valid", cmp_valid, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_out_wdata", out_wdata, 0);
        rst = 1'b0;

        // 2x2 map, latency 1
        mem[0] = 32'h0003_0005;
        mem[1] = 32'h0009_0001;
        run_map(1, 2, 1, 0, "m2x2");
        chk("m2x2_val", wr_data.size() > 0 ? 32'(wr_data[0]) : 32'hdead, 32'h9);

        // 4x4 ramp, latency 1 then 5
        load_ramp(2, 4);
        run_map(2, 4, 1, 0, "m4x4");
        chk("m4x4_w3", wr_data.size() > 3 ? 32'(wr_data[3]) : 32'hdead, 32'h33);
        run_map(2, 4, 5, 0, "m4x4_l5");
        chk("m4x4_l5_w1", wr_data.size() > 1 ? 32'(wr_data[1]) : 32'hdead, 32'h13);

        // Odd final row dropped, degenerate shapes
        mem[0] = 32'h0001_0002; mem[1] = 32'h0004_0003; mem[2] = 32'h7fff_7fff;
        run_map(1, 3, 2, 0, "rows3");
        run_map(1, 1, 1, 0, "rows1");
        run_map(0, 4, 1, 0, "words0");

        // Spurious strobe in IDLE sets sticky err; next start clears it
        @(negedge clk);
        inj_d = 16'h1234; inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        chk("spur_err_set", err, 1);
        repeat (5) @(negedge clk);
        chk("spur_err_sticky", err, 1);
        chk("spur_still_idle", busy, 0);
        load_ramp(2, 4);
        run_map(2, 4, 3, 0, "after_spur");

        // Reset in WAIT_F aborts without a write
        lat = 5;
        clear_mon();
        @(negedge clk);
        cfg_words = 2; cfg_rows = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cv_cnt < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_fin", cv_cnt, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cmp_valid", cmp_valid, 0);
        chk("abort_in_en", in_en, 0);
        chk("abort_out_wdata", out_wdata, 0);
        repeat (8) @(negedge clk);
        chk("abort_no_write", wr_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_err", err, 0);
        chk("abort_out_we", out_we, 0);
        run_map(2, 4, 5, 0, "after_rst");

        // Randomized maps, latencies and ignored mid-run starts
        for (int k = 0; k < 8; k++) begin
            int w, r, l;
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            w = $urandom_range(0, 4);
            r = $urandom_range(0, 7);
            l = $urandom_range(1, 6);
            run_map(w, r, l, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_w%0d_r%0d_l%0d", k, w, r, l));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
